// File: rtl/alu_parity_pipe.sv
// Three-stage ALU pipeline: Fetch registers the operands, Execute computes result/carry/illegal,
// Parity registers the outputs with a parity bit. Valid/ready on both sides, bubbles collapse.
module alu_parity_pipe #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned CODE_W     = 16,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] code,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              parity,
    output logic              carry,
    output logic              illegal
);

    localparam int unsigned ShW = $clog2(WIDTH);
    localparam logic OddBit = (PARITY_ODD != 0);

    localparam logic [CODE_W-1:0] OpAnd  = CODE_W'(1);
    localparam logic [CODE_W-1:0] OpOr   = CODE_W'(2);
    localparam logic [CODE_W-1:0] OpXor  = CODE_W'(3);
    localparam logic [CODE_W-1:0] OpAdd  = CODE_W'(4);
    localparam logic [CODE_W-1:0] OpSub  = CODE_W'(5);
    localparam logic [CODE_W-1:0] OpSll  = CODE_W'(6);
    localparam logic [CODE_W-1:0] OpSrl  = CODE_W'(7);
    localparam logic [CODE_W-1:0] OpPass = CODE_W'(8);

    // Fetch stage
    logic              f_valid_q, f_valid_d;
    logic [CODE_W-1:0] f_code_q, f_code_d;
    logic [WIDTH-1:0]  f_a_q, f_a_d;
    logic [WIDTH-1:0]  f_b_q, f_b_d;

    // Execute stage
    logic              e_valid_q, e_valid_d;
    logic [WIDTH-1:0]  e_result_q, e_result_d;
    logic              e_carry_q, e_carry_d;
    logic              e_illegal_q, e_illegal_d;

    // Parity stage
    logic              p_valid_q, p_valid_d;
    logic [WIDTH-1:0]  p_result_q, p_result_d;
    logic              p_parity_q, p_parity_d;
    logic              p_carry_q, p_carry_d;
    logic              p_illegal_q, p_illegal_d;

    logic              p_ready, e_ready, f_ready, f_load;

    logic [WIDTH:0]    sum_w, diff_w;
    logic [ShW-1:0]    shamt;
    logic [WIDTH-1:0]  exe_result;
    logic              exe_carry, exe_illegal;

    // A stage can take new data when it is empty or its contents move on this cycle.
    always_comb begin
        p_ready  = !p_valid_q || out_ready;
        e_ready  = !e_valid_q || p_ready;
        f_ready  = !f_valid_q || e_ready;
        in_ready = f_ready && !rst;
        f_load   = in_valid && in_ready;
    end

    always_comb begin
        sum_w       = {1'b0, f_a_q} + {1'b0, f_b_q};
        diff_w      = {1'b0, f_a_q} - {1'b0, f_b_q};
        shamt       = f_b_q[ShW-1:0];
        exe_result  = '0;
        exe_carry   = 1'b0;
        exe_illegal = 1'b0;
        case (f_code_q)
            OpAnd:  exe_result = f_a_q & f_b_q;
            OpOr:   exe_result = f_a_q | f_b_q;
            OpXor:  exe_result = f_a_q ^ f_b_q;
            OpAdd: begin
                exe_result = sum_w[WIDTH-1:0];
                exe_carry  = sum_w[WIDTH];
            end
            OpSub: begin
                // Top bit of the widened difference is the unsigned borrow.
                exe_result = diff_w[WIDTH-1:0];
                exe_carry  = diff_w[WIDTH];
            end
            OpSll:  exe_result = f_a_q << shamt;
            OpSrl:  exe_result = f_a_q >> shamt;
            OpPass: exe_result = f_a_q;
            default: exe_illegal = 1'b1;
        endcase
    end

    always_comb begin
        f_valid_d   = f_valid_q;
        f_code_d    = f_code_q;
        f_a_d       = f_a_q;
        f_b_d       = f_b_q;
        e_valid_d   = e_valid_q;
        e_result_d  = e_result_q;
        e_carry_d   = e_carry_q;
        e_illegal_d = e_illegal_q;
        p_valid_d   = p_valid_q;
        p_result_d  = p_result_q;
        p_parity_d  = p_parity_q;
        p_carry_d   = p_carry_q;
        p_illegal_d = p_illegal_q;

        if (f_load) begin
            f_valid_d = 1'b1;
            f_code_d  = code;
            f_a_d     = A;
            f_b_d     = B;
        end else if (e_ready) begin
            f_valid_d = 1'b0;
        end

        if (e_ready) begin
            e_valid_d = f_valid_q;
            if (f_valid_q) begin
                e_result_d  = exe_result;
                e_carry_d   = exe_carry;
                e_illegal_d = exe_illegal;
            end
        end

        // Output fields only change on a load, so they hold steady while stalled.
        if (p_ready) begin
            p_valid_d = e_valid_q;
            if (e_valid_q) begin
                p_result_d  = e_result_q;
                p_parity_d  = (^e_result_q) ^ OddBit;
                p_carry_d   = e_carry_q;
                p_illegal_d = e_illegal_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_valid_q   <= 1'b0;
            f_code_q    <= '0;
            f_a_q       <= '0;
            f_b_q       <= '0;
            e_valid_q   <= 1'b0;
            e_result_q  <= '0;
            e_carry_q   <= 1'b0;
            e_illegal_q <= 1'b0;
            p_valid_q   <= 1'b0;
            p_result_q  <= '0;
            p_parity_q  <= 1'b0;
            p_carry_q   <= 1'b0;
            p_illegal_q <= 1'b0;
        end else begin
            f_valid_q   <= f_valid_d;
            f_code_q    <= f_code_d;
            f_a_q       <= f_a_d;
            f_b_q       <= f_b_d;
            e_valid_q   <= e_valid_d;
            e_result_q  <= e_result_d;
            e_carry_q   <= e_carry_d;
            e_illegal_q <= e_illegal_d;
            p_valid_q   <= p_valid_d;
            p_result_q  <= p_result_d;
            p_parity_q  <= p_parity_d;
            p_carry_q   <= p_carry_d;
            p_illegal_q <= p_illegal_d;
        end
    end

    always_comb begin
        out_valid = p_valid_q;
        result    = p_result_q;
        parity    = p_parity_q;
        carry     = p_carry_q;
        illegal   = p_illegal_q;
    end

endmodule

// File: tb/tb_alu_parity_pipe.sv
// Bench for alu_parity_pipe: directed scenarios plus a randomized stream against a queue model.
// A second instance with odd parity shares the stimulus.
module tb_alu_parity_pipe;

    localparam int W  = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [CW-1:0] code = '0;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;

    logic          in_ready, out_valid, parity, carry, illegal;
    logic [W-1:0]  result;
    logic          o_in_ready, o_out_valid, o_parity, o_carry, o_illegal;
    logic [W-1:0]  o_result;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [W-1:0] r;
        logic         p;
        logic         c;
        logic         i;
    } exp_t;

    always #5 clk = ~clk;

    alu_parity_pipe #(.WIDTH(W), .CODE_W(CW), .PARITY_ODD(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .code(code),
        .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .parity(parity), .carry(carry), .illegal(illegal)
    );

    alu_parity_pipe #(.WIDTH(W), .CODE_W(CW), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_in_ready), .code(code),
        .A(A), .B(B), .out_valid(o_out_valid), .out_ready(out_ready), .result(o_result),
        .parity(o_parity), .carry(o_carry), .illegal(o_illegal)
    );

    // Reference: plain arithmetic on the opcode table, parity by population count (even mode).
    function automatic exp_t model(input logic [CW-1:0] c, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t e;
        logic [4:0] sh;
        longint unsigned s;
        e = '0;
        sh = b[4:0];
        case (c)
            16'h0001: e.r = a & b;
            16'h0002: e.r = a | b;
            16'h0003: e.r = a ^ b;
            16'h0004: begin
                e.r = a + b;
                s = longint'(a) + longint'(b);
                e.c = (s > 64'h0000_0000_FFFF_FFFF);
            end
            16'h0005: begin
                e.r = a - b;
                e.c = (a < b);
            end
            16'h0006: e.r = a << sh;
            16'h0007: e.r = a >> sh;
            16'h0008: e.r = a;
            default:  e.i = 1'b1;
        endcase
        e.p = ($countones(e.r) % 2) == 1;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op with out_ready high; returns cycles from accepting edge to out_valid.
    task automatic send_one(input logic [CW-1:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                            output int lat);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        code = c;
        A = a;
        B = b;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        code = 16'h0004;
        A = 32'h2;
        B = 32'h2;
        repeat (2) step();
        tests_run++;
        if ({out_valid, result, parity, carry, illegal} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got v=%b r=%h p=%b c=%b i=%b required all 0",
                     out_valid, result, parity, carry, illegal);
        end
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b required 0", in_ready);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL release_in_ready: got %b required 1", in_ready);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_no_accept: cycle %0d out_valid=%b required 0", k, out_valid);
            end
        end
    endtask

    task automatic test_add();
        int lat;
        send_one(16'h0004, 32'h2, 32'h2, lat);
        tests_run++;
        if (lat !== 3) begin
            tests_failed++;
            $display("FAIL add_latency: got %0d required 3", lat);
        end
        tests_run++;
        if ({result, parity, carry, illegal, o_parity} !== {32'h4, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL add_value: got r=%h p=%b c=%b i=%b op=%b required r=4 p=1 c=0 i=0 op=0",
                     result, parity, carry, illegal, o_parity);
        end
        step();
    endtask

    task automatic test_wrap();
        int lat;
        send_one(16'h0004, 32'hFFFF_FFFF, 32'h1, lat);
        tests_run++;
        if ({result, parity, carry, illegal} !== {32'h0, 1'b0, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL add_wrap: got r=%h p=%b c=%b i=%b required r=0 p=0 c=1 i=0",
                     result, parity, carry, illegal);
        end
        step();
        send_one(16'h0005, 32'h1, 32'h2, lat);
        tests_run++;
        if ({result, parity, carry, illegal} !== {32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL sub_borrow: got r=%h p=%b c=%b i=%b required r=ffffffff p=0 c=1 i=0",
                     result, parity, carry, illegal);
        end
        step();
    endtask

    task automatic test_illegal();
        int lat;
        logic [CW-1:0] codes [2];
        codes[0] = 16'h00FF;
        codes[1] = 16'h0000;
        for (int k = 0; k < 2; k++) begin
            send_one(codes[k], $urandom, $urandom, lat);
            tests_run++;
            if ({result, parity, carry, illegal, o_parity, o_illegal} !==
                {32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1}) begin
                tests_failed++;
                $display("FAIL illegal_%h: got r=%h p=%b c=%b i=%b op=%b oi=%b required r=0 p=0 c=0 i=1 op=1 oi=1",
                         codes[k], result, parity, carry, illegal, o_parity, o_illegal);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        exp_t exp_q[$];
        exp_t e, held;
        logic [CW-1:0] ops_c [5];
        logic [W-1:0]  ops_a [5];
        logic [W-1:0]  ops_b [5];
        int sent = 0;
        int got = 0;
        bit was_stalled = 0;
        bit acc;
        for (int k = 0; k < 5; k++) begin
            ops_c[k] = CW'($urandom_range(1, 8));
            ops_a[k] = $urandom;
            ops_b[k] = $urandom;
        end
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 6);
            in_valid = (sent < 5);
            if (sent < 5) begin
                code = ops_c[sent];
                A = ops_a[sent];
                B = ops_b[sent];
            end
            #1;
            if (cyc == 3) begin
                tests_run++;
                if ({in_ready, 3'(sent)} !== {1'b0, 3'd3}) begin
                    tests_failed++;
                    $display("FAIL bp_in_ready_drop: got in_ready=%b accepted=%0d required 0 and 3",
                             in_ready, sent);
                end
            end
            if (was_stalled) begin
                tests_run++;
                if ({out_valid, result, parity, carry, illegal} !== {1'b1, held}) begin
                    tests_failed++;
                    $display("FAIL bp_stable: cycle %0d got v=%b %h required v=1 %h",
                             cyc, out_valid, {result, parity, carry, illegal}, held);
                end
            end
            was_stalled = out_valid && !out_ready;
            held = {result, parity, carry, illegal};
            acc = in_valid && in_ready;
            if (acc) exp_q.push_back(model(code, A, B));
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                tests_run++;
                if ({result, parity, carry, illegal} !== e) begin
                    tests_failed++;
                    $display("FAIL bp_result_%0d: got %h required %h",
                             got, {result, parity, carry, illegal}, e);
                end
                got++;
            end
            step();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        tests_run++;
        if (got !== 5) begin
            tests_failed++;
            $display("FAIL bp_count: got %0d results required 5", got);
        end
    endtask

    task automatic test_random();
        exp_t exp_q[$];
        exp_t e, held;
        bit was_stalled = 0;
        int outs = 0;
        for (int cyc = 0; cyc < 460; cyc++) begin
            out_ready = (cyc >= 400) ? 1'b1 : ($urandom_range(0, 2) != 0);
            in_valid  = (cyc < 400) && ($urandom_range(0, 3) != 0);
            code = ($urandom_range(0, 7) == 0) ? CW'($urandom) : CW'($urandom_range(0, 9));
            A = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
            B = ($urandom_range(0, 5) == 0) ? A : $urandom;
            #1;
            if (was_stalled) begin
                tests_run++;
                if ({out_valid, result, parity, carry, illegal} !== {1'b1, held}) begin
                    tests_failed++;
                    $display("FAIL rnd_stable: cycle %0d got %h required %h",
                             cyc, {result, parity, carry, illegal}, held);
                end
            end
            was_stalled = out_valid && !out_ready;
            held = {result, parity, carry, illegal};
            if (in_valid && in_ready) exp_q.push_back(model(code, A, B));
            if (out_valid && out_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL rnd_spurious: cycle %0d unexpected output %h", cyc, result);
                end else begin
                    e = exp_q.pop_front();
                    if ({result, parity, carry, illegal, o_result, o_parity} !==
                        {e, e.r, ~e.p}) begin
                        tests_failed++;
                        $display("FAIL rnd_result_%0d: got %h odd_p=%b required %h odd_p=%b",
                                 outs, {result, parity, carry, illegal}, o_parity, e, ~e.p);
                    end
                end
                outs++;
            end
            step();
        end
        in_valid = 1'b0;
        tests_run++;
        if (exp_q.size() != 0 || outs < 50) begin
            tests_failed++;
            $display("FAIL rnd_drain: got %0d pending %0d delivered required 0 pending >=50 delivered",
                     exp_q.size(), outs);
        end
    endtask

    task automatic test_midflight_reset();
        int lat;
        exp_t e;
        out_ready = 1'b1;
        in_valid = 1'b1;
        code = 16'h0001;
        A = $urandom;
        B = $urandom;
        step();
        code = 16'h0003;
        A = $urandom;
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL midrst_flush: cycle %0d out_valid=%b required 0", k, out_valid);
            end
            step();
        end
        e = model(16'h0006, 32'h0000_00F1, 32'h0000_0024);
        send_one(16'h0006, 32'h0000_00F1, 32'h0000_0024, lat);
        tests_run++;
        if (lat !== 3 || {result, parity, carry, illegal} !== e) begin
            tests_failed++;
            $display("FAIL midrst_next: got lat=%0d %h required lat=3 %h",
                     lat, {result, parity, carry, illegal}, e);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_wrap();
        test_illegal();
        test_back_to_back();
        test_random();
        test_midflight_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_parity_pipe.md
ALU_PARITY_PIPE -- requirements
Module: alu_parity_pipe

Interface
REQ-001 The block SHALL have one clock, clk; reset rst SHALL be synchronous and active-high.
REQ-002 Parameter WIDTH, default 32: operand and result width, 8 to 64.
REQ-003 Parameter CODE_W, default 16: opcode width, 4 or more.
REQ-004 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 in_valid  in  1  code/A/B hold a transaction.
REQ-008 in_ready  out  1  block accepts a transaction this cycle.
REQ-009 code  in  CODE_W  opcode.
REQ-010 A  in  WIDTH  operand A.
REQ-011 B  in  WIDTH  operand B.
REQ-012 out_valid  out  1  result/parity/carry/illegal hold a completed transaction.
REQ-013 out_ready  in  1  downstream consumes the output this cycle.
REQ-014 result  out  WIDTH  ALU result.
REQ-015 parity  out  1  parity bit over result.
REQ-016 carry  out  1  ADD carry-out or SUB borrow.
REQ-017 illegal  out  1  opcode not recognised.

Function
REQ-018 The block SHALL implement three registered stages, in order: Fetch (capture code/A/B), Execute (compute result/carry/illegal), Parity (compute parity, drive outputs).
REQ-019 A transfer SHALL occur on a rising edge when in_valid and in_ready are both high; an output transfer SHALL occur when out_valid and out_ready are both high.
REQ-020 With no backpressure, out_valid SHALL rise 3 cycles after the accepting edge; throughput SHALL be one transaction per cycle.
REQ-021 Each stage SHALL advance when its successor is empty or advancing; in_ready SHALL be combinational: Fetch stage empty, or Fetch stage advancing.
REQ-022 Bubbles SHALL collapse: under out_ready low, up to 3 transactions SHALL be held, one per stage, and none lost or duplicated.
REQ-023 While out_valid is high and out_ready is low, result, parity, carry and illegal SHALL remain stable.
REQ-024 Opcodes, using the low bits of code with all upper bits zero: 0x0001 AND; 0x0002 OR; 0x0003 XOR; 0x0004 ADD; 0x0005 SUB (A-B); 0x0006 SLL A by B[clog2(WIDTH)-1:0]; 0x0007 SRL likewise; 0x0008 PASS A.
REQ-025 ADD and SUB SHALL wrap modulo 2^WIDTH; carry SHALL be the ADD carry-out, SUB borrow (1 when A<B unsigned), and 0 for every other opcode.
REQ-026 Any other code value, including 0x0000, SHALL give result=0, carry=0, illegal=1, with parity computed normally over 0.
REQ-027 parity SHALL be the XOR-reduction of result when PARITY_ODD=0, and its inverse when PARITY_ODD=1.
REQ-028 Simultaneous input acceptance and output consumption in one cycle SHALL both take effect.

Reset
REQ-029 While rst is high at a clock edge, all stage valid bits SHALL clear, and out_valid, result, parity, carry and illegal SHALL become 0.
REQ-030 in_ready SHALL be 0 while rst is asserted and 1 on the first cycle after release.
REQ-031 Reset mid-operation SHALL discard all in-flight transactions; none SHALL appear at the output afterwards.

Verification
REQ-032 Reset: hold rst for 2 cycles with in_valid=1 -> out_valid=0 and all outputs 0; no transaction is accepted.
REQ-033 ADD: code=0x0004, A=0x00000002, B=0x00000002, out_ready=1 -> 3 cycles later result=0x00000004, parity=1, carry=0, illegal=0.
REQ-034 Wrap: ADD with A=0xFFFFFFFF, B=0x00000001 -> result=0, carry=1, parity=0; SUB with A=1, B=2 -> result=0xFFFFFFFF, carry=1, parity=0.
REQ-035 Backpressure: stream 5 back-to-back ops with out_ready low for cycles 3-6 -> in_ready drops after 3 accepted; all 5 results emerge in order, unchanged while stalled.
REQ-036 Illegal: code=0x00FF -> result=0, illegal=1, parity=0; with PARITY_ODD=1 -> parity=1.
REQ-037 Mid-flight reset: accept 2 ops, assert rst one cycle before the first would emerge -> out_valid stays 0; the next op after reset emerges with correct latency 3.
